// File: rtl/usb3_host_xfer_pkg.sv
// Shared definitions for the USB3 host transfer engine: TP subtype codes,
// direction/retry constants and the transfer state encoding.
package usb3_host_xfer_pkg;

  localparam logic [3:0] LP_TP_SUB_ACK   = 4'd1;
  localparam logic [3:0] LP_TP_SUB_NRDY  = 4'd2;
  localparam logic [3:0] LP_TP_SUB_ERDY  = 4'd3;
  localparam logic [3:0] LP_TP_SUB_STALL = 4'd5;

  localparam logic LP_TP_DIR_IN  = 1'b1;
  localparam logic LP_TP_DIR_OUT = 1'b0;
  localparam logic LP_TP_RETRY   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_IN_REQ    = 4'd1,
    ST_IN_WAIT   = 4'd2,
    ST_IN_DPP    = 4'd3,
    ST_IN_ACK    = 4'd4,
    ST_OUT_DPH   = 4'd5,
    ST_OUT_DPP   = 4'd6,
    ST_OUT_WAIT  = 4'd7,
    ST_ERDY_WAIT = 4'd8,
    ST_DONE      = 4'd9
  } xfer_state_t;

  // States in which the device owes us a response and the abort timer runs.
  function automatic logic timed_state(input xfer_state_t s);
    return (s == ST_IN_WAIT) || (s == ST_IN_DPP) || (s == ST_OUT_WAIT);
  endfunction

endpackage

// File: rtl/usb3_xfer_timer.sv
// Wait-state counter: load restarts it, expired flags the TIMEOUT-th cycle
// spent running in the current state.
module usb3_xfer_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic local_clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // The load cycle already counts as the first cycle in the new state.
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= run ? W'(1) : '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && !load && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/usb3_host_xfer.sv
// USB3 host-side transfer sequencer: issues ACK TPs / DPHs to the link and
// tracks device responses, sequence numbers, retries and timeouts.
module usb3_host_xfer
  import usb3_host_xfer_pkg::*;
#(
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 3
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [3:0]  cmd_endp,
  input  logic [15:0] cmd_len,
  output logic        tx_tp,
  output logic        tx_tp_pktpend,
  output logic [3:0]  tx_tp_subtype,
  output logic [3:0]  tx_tp_endp,
  output logic [4:0]  tx_tp_nump,
  output logic [4:0]  tx_tp_seq,
  input  logic        tx_tp_ack,
  output logic        tx_dph,
  output logic [3:0]  tx_dph_endp,
  output logic [4:0]  tx_dph_seq,
  output logic [15:0] tx_dph_len,
  input  logic        tx_dpp_ack,
  input  logic        tx_dpp_done,
  input  logic        rx_tp,
  input  logic        rx_tp_retry,
  input  logic [3:0]  rx_tp_subtype,
  input  logic [4:0]  rx_tp_seq,
  input  logic [4:0]  rx_tp_nump,
  input  logic        rx_dph,
  input  logic [4:0]  rx_dph_seq,
  input  logic [15:0] rx_dph_len,
  input  logic        rx_dpp_done,
  input  logic        rx_dpp_crcgood,
  output logic        xfer_done,
  output logic [15:0] xfer_len,
  output logic        err_timeout,
  output logic        err_retry,
  output logic        err_stall,
  output logic [3:0]  fsm_state
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  xfer_state_t   state, prev_state;
  logic          dir_q;
  logic [3:0]    endp_q;
  logic [15:0]   len_q, rx_len_q;
  logic [4:0]    in_seq, out_seq;
  logic [RW-1:0] retry_cnt;
  logic          timer_expired, retry_over, tp_seen;
  logic          unused_rx_nump;

  assign unused_rx_nump = ^rx_tp_nump;
  // A DPH in the same cycle as a TP wins; the TP is dropped.
  assign tp_seen    = rx_tp && !rx_dph;
  assign retry_over = (retry_cnt >= RW'(MAX_RETRY));

  usb3_xfer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .load      (state != prev_state),
    .run       (timed_state(state)),
    .expired   (timer_expired)
  );

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prev_state  <= ST_IDLE;
      cmd_ready   <= 1'b0;
      dir_q       <= 1'b0;
      endp_q      <= '0;
      len_q       <= '0;
      rx_len_q    <= '0;
      in_seq      <= '0;
      out_seq     <= '0;
      retry_cnt   <= '0;
      xfer_done   <= 1'b0;
      xfer_len    <= '0;
      err_timeout <= 1'b0;
      err_retry   <= 1'b0;
      err_stall   <= 1'b0;
    end else begin
      prev_state <= state;
      xfer_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            dir_q     <= cmd_dir;
            endp_q    <= cmd_endp;
            len_q     <= cmd_len;
            rx_len_q  <= '0;
            retry_cnt <= '0;
            state     <= (cmd_dir == LP_TP_DIR_IN) ? ST_IN_REQ : ST_OUT_DPH;
          end
        end
        ST_IN_REQ: if (tx_tp_ack) state <= ST_IN_WAIT;
        ST_IN_WAIT: begin
          if (rx_dph && (rx_dph_seq == in_seq)) begin
            rx_len_q <= rx_dph_len;
            state    <= ST_IN_DPP;
          end else if (tp_seen && (rx_tp_subtype == LP_TP_SUB_NRDY)) begin
            state <= ST_ERDY_WAIT;
          end else if (tp_seen && (rx_tp_subtype == LP_TP_SUB_STALL)) begin
            err_stall <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end else if (timer_expired) begin
            err_timeout <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end
        end
        ST_IN_DPP: begin
          if (rx_dpp_done && rx_dpp_crcgood) begin
            in_seq <= in_seq + 5'd1;
            state  <= ST_IN_ACK;
          end else if (rx_dpp_done && retry_over) begin
            err_retry <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end else if (rx_dpp_done) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= ST_IN_REQ;
          end else if (timer_expired) begin
            err_timeout <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end
        end
        ST_IN_ACK: if (tx_tp_ack) begin
          xfer_done <= 1'b1; xfer_len <= rx_len_q; state <= ST_DONE;
        end
        ST_OUT_DPH: if (tx_dpp_ack) state <= ST_OUT_DPP;
        ST_OUT_DPP: if (tx_dpp_done) state <= ST_OUT_WAIT;
        ST_OUT_WAIT: begin
          if (tp_seen && (rx_tp_subtype == LP_TP_SUB_ACK)) begin
            if ((rx_tp_retry != LP_TP_RETRY) && (rx_tp_seq == 5'(out_seq + 5'd1))) begin
              out_seq <= out_seq + 5'd1;
              xfer_done <= 1'b1; xfer_len <= len_q; state <= ST_DONE;
            end else if (retry_over) begin
              err_retry <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_OUT_DPH;
            end
          end else if (tp_seen && (rx_tp_subtype == LP_TP_SUB_NRDY)) begin
            state <= ST_ERDY_WAIT;
          end else if (tp_seen && (rx_tp_subtype == LP_TP_SUB_STALL)) begin
            err_stall <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end else if (timer_expired) begin
            err_timeout <= 1'b1; xfer_done <= 1'b1; xfer_len <= '0; state <= ST_DONE;
          end
        end
        ST_ERDY_WAIT: if (tp_seen && (rx_tp_subtype == LP_TP_SUB_ERDY)) begin
          state <= (dir_q == LP_TP_DIR_IN) ? ST_IN_REQ : ST_OUT_DPH;
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Link requests are decoded from the state register, so they hold steady
  // until the ack edge moves the FSM on and read as zero everywhere else.
  assign tx_tp         = (state == ST_IN_REQ) || (state == ST_IN_ACK);
  assign tx_tp_pktpend = (state == ST_IN_REQ);
  assign tx_tp_subtype = tx_tp ? LP_TP_SUB_ACK : 4'd0;
  assign tx_tp_endp    = tx_tp ? endp_q : 4'd0;
  assign tx_tp_nump    = (state == ST_IN_REQ) ? 5'd1 : 5'd0;
  assign tx_tp_seq     = tx_tp ? in_seq : 5'd0;
  assign tx_dph        = (state == ST_OUT_DPH);
  assign tx_dph_endp   = tx_dph ? endp_q : 4'd0;
  assign tx_dph_seq    = tx_dph ? out_seq : 5'd0;
  assign tx_dph_len    = tx_dph ? len_q : 16'd0;
  assign fsm_state     = state;

endmodule

// File: tb/tb_usb3_host_xfer.sv
// Self-checking bench for usb3_host_xfer: table-driven transfers plus
// hand-written error, priority, wrap and reset sequences.
module tb_usb3_host_xfer;

  localparam int TIMEOUT   = 1023;
  localparam int MAX_RETRY = 3;
  localparam logic [3:0] SUB_ACK = 4'd1, SUB_NRDY = 4'd2, SUB_ERDY = 4'd3, SUB_STALL = 4'd5;

  logic local_clk, reset_n;
  logic cmd_valid, cmd_ready, cmd_dir;
  logic [3:0] cmd_endp;
  logic [15:0] cmd_len;
  logic tx_tp, tx_tp_pktpend, tx_tp_ack;
  logic [3:0] tx_tp_subtype, tx_tp_endp;
  logic [4:0] tx_tp_nump, tx_tp_seq;
  logic tx_dph, tx_dpp_ack, tx_dpp_done;
  logic [3:0] tx_dph_endp;
  logic [4:0] tx_dph_seq;
  logic [15:0] tx_dph_len;
  logic rx_tp, rx_tp_retry;
  logic [3:0] rx_tp_subtype;
  logic [4:0] rx_tp_seq, rx_tp_nump;
  logic rx_dph;
  logic [4:0] rx_dph_seq;
  logic [15:0] rx_dph_len;
  logic rx_dpp_done, rx_dpp_crcgood;
  logic xfer_done;
  logic [15:0] xfer_len;
  logic err_timeout, err_retry, err_stall;
  logic [3:0] fsm_state;

  usb3_host_xfer #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .local_clk(local_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_endp(cmd_endp), .cmd_len(cmd_len),
    .tx_tp(tx_tp), .tx_tp_pktpend(tx_tp_pktpend), .tx_tp_subtype(tx_tp_subtype),
    .tx_tp_endp(tx_tp_endp), .tx_tp_nump(tx_tp_nump), .tx_tp_seq(tx_tp_seq),
    .tx_tp_ack(tx_tp_ack),
    .tx_dph(tx_dph), .tx_dph_endp(tx_dph_endp), .tx_dph_seq(tx_dph_seq),
    .tx_dph_len(tx_dph_len), .tx_dpp_ack(tx_dpp_ack), .tx_dpp_done(tx_dpp_done),
    .rx_tp(rx_tp), .rx_tp_retry(rx_tp_retry), .rx_tp_subtype(rx_tp_subtype),
    .rx_tp_seq(rx_tp_seq), .rx_tp_nump(rx_tp_nump),
    .rx_dph(rx_dph), .rx_dph_seq(rx_dph_seq), .rx_dph_len(rx_dph_len),
    .rx_dpp_done(rx_dpp_done), .rx_dpp_crcgood(rx_dpp_crcgood),
    .xfer_done(xfer_done), .xfer_len(xfer_len),
    .err_timeout(err_timeout), .err_retry(err_retry), .err_stall(err_stall),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    local_clk = 1'b0;
    forever #5 local_clk = ~local_clk;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [4:0] in_m = 5'd0;
  logic [4:0] out_m = 5'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge local_clk) begin
    if (reset_n && xfer_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=xfer_done expected=no completion");
      end else begin
        check("xfer_len", {16'd0, xfer_len}, {16'd0, exp_q.pop_front()});
      end
      done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    exp_q.delete();
    in_m = 5'd0;
    out_m = 5'd0;
  endtask

  task automatic issue(input logic dir, input logic [3:0] endp, input logic [15:0] len,
                       input logic [15:0] exp_len);
    int n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_endp = endp; cmd_len = len;
    exp_q.push_back(exp_len);
    tick();
    cmd_valid = 1'b0;
    cmd_endp  = 4'($urandom_range(0, 15));
    cmd_len   = 16'($urandom_range(0, 65535));
  endtask

  task automatic expect_tp(input logic pp, input logic [4:0] nump, input logic [4:0] seq,
                           input logic [3:0] endp, input string nm);
    int n = 0;
    while (!tx_tp && n < 50) begin tick(); n++; end
    check({nm, "_req"}, tx_tp, 1);
    check({nm, "_pktpend"}, tx_tp_pktpend, pp);
    check({nm, "_subtype"}, tx_tp_subtype, SUB_ACK);
    check({nm, "_nump"}, tx_tp_nump, nump);
    check({nm, "_seq"}, tx_tp_seq, seq);
    check({nm, "_endp"}, tx_tp_endp, endp);
    tick();
    check({nm, "_hold"}, {tx_tp, tx_tp_seq}, {1'b1, seq});
    tx_tp_ack = 1'b1;
    tick();
    tx_tp_ack = 1'b0;
    check({nm, "_drop"}, tx_tp, 0);
  endtask

  task automatic expect_dph(input logic [4:0] seq, input logic [15:0] len,
                            input logic [3:0] endp, input string nm);
    int n = 0;
    while (!tx_dph && n < 50) begin tick(); n++; end
    check({nm, "_req"}, tx_dph, 1);
    check({nm, "_seq"}, tx_dph_seq, seq);
    check({nm, "_len"}, tx_dph_len, len);
    check({nm, "_endp"}, tx_dph_endp, endp);
    tick();
    tx_dpp_ack = 1'b1;
    tick();
    tx_dpp_ack = 1'b0;
    check({nm, "_drop"}, tx_dph, 0);
    tick();
    tx_dpp_done = 1'b1;
    tick();
    tx_dpp_done = 1'b0;
  endtask

  task automatic send_tp(input logic [3:0] sub, input logic retry, input logic [4:0] seq);
    rx_tp = 1'b1; rx_tp_subtype = sub; rx_tp_retry = retry; rx_tp_seq = seq;
    rx_tp_nump = 5'($urandom_range(0, 31));
    tick();
    rx_tp = 1'b0;
  endtask

  task automatic send_dph(input logic [4:0] seq, input logic [15:0] len);
    rx_dph = 1'b1; rx_dph_seq = seq; rx_dph_len = len;
    tick();
    rx_dph = 1'b0;
  endtask

  task automatic send_dpp(input logic good);
    rx_dpp_done = 1'b1; rx_dpp_crcgood = good;
    tick();
    rx_dpp_done = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < 100) begin tick(); n++; end
    check({nm, "_done_seen"}, done_cnt - start, 1);
    check({nm, "_done_pulse"}, xfer_done, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dir;
    logic [3:0]  endp;
    logic [15:0] len;
    int          nbad;
    logic        wrong;
    logic [15:0] exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    issue(v.dir, v.endp, v.dir ? 16'($urandom_range(0, 65535)) : v.len, v.exp_len);
    if (v.dir) begin
      for (int a = 0; a <= v.nbad; a++) begin
        expect_tp(1'b1, 5'd1, in_m, v.endp, "in_req");
        if (a == 0 && v.wrong) send_dph(in_m + 5'd1, 16'hdead);
        send_dph(in_m, v.len);
        send_dpp(a == v.nbad);
      end
      in_m = in_m + 5'd1;
      expect_tp(1'b0, 5'd0, in_m, v.endp, "in_ack");
    end else begin
      for (int a = 0; a <= v.nbad; a++) begin
        expect_dph(out_m, v.len, v.endp, "out_dph");
        if (a < v.nbad) send_tp(SUB_ACK, !v.wrong, v.wrong ? out_m + 5'd2 : out_m + 5'd1);
        else send_tp(SUB_ACK, 1'b0, out_m + 5'd1);
      end
      out_m = out_m + 5'd1;
    end
    wait_done("vec");
    check("vec_errs", {err_timeout, err_retry, err_stall}, 3'b000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    cmd_valid = 0; cmd_dir = 0; cmd_endp = 0; cmd_len = 0;
    tx_tp_ack = 0; tx_dpp_ack = 0; tx_dpp_done = 0;
    rx_tp = 0; rx_tp_retry = 0; rx_tp_subtype = 0; rx_tp_seq = 0; rx_tp_nump = 0;
    rx_dph = 0; rx_dph_seq = 0; rx_dph_len = 0; rx_dpp_done = 0; rx_dpp_crcgood = 0;
    repeat (3) tick();

    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_state", fsm_state, 4'd0);
    check("rst_reqs", {tx_tp, tx_dph, xfer_done}, 3'b000);
    check("rst_errs", {err_timeout, err_retry, err_stall}, 3'b000);
    check("rst_xfer_len", xfer_len, 16'd0);
    check("rst_tp_fields", {tx_tp_pktpend, tx_tp_subtype, tx_tp_endp, tx_tp_nump, tx_tp_seq}, 19'd0);
    check("rst_dph_fields", {tx_dph_endp, tx_dph_seq, tx_dph_len}, 25'd0);
    reset_n = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    // Receive strobes while idle must not move the FSM.
    rx_tp = 1'b1; rx_tp_subtype = SUB_ERDY; rx_dph = 1'b1; rx_dpp_done = 1'b1;
    tick();
    rx_tp = 1'b0; rx_dph = 1'b0; rx_dpp_done = 1'b0;
    tick();
    check("idle_ignore_state", fsm_state, 4'd0);
    check("idle_ignore_ready", cmd_ready, 1);

    vecs[0] = '{1'b1, 4'd1, 16'd512, 0, 1'b0, 16'd512};
    vecs[1] = '{1'b0, 4'd2, 16'd64, 2, 1'b0, 16'd64};
    vecs[2] = '{1'b1, 4'd3, 16'd100, 1, 1'b0, 16'd100};
    vecs[3] = '{1'b0, 4'd4, 16'd0, 0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 4'd5, 16'd1024, 0, 1'b1, 16'd1024};
    vecs[5] = '{1'b0, 4'd6, 16'd1500, 1, 1'b1, 16'd1500};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // IN with NRDY, then ERDY: request is reissued with the same seq.
    issue(1'b1, 4'd1, 16'd0, 16'd128);
    expect_tp(1'b1, 5'd1, in_m, 4'd1, "nr_req1");
    send_tp(SUB_NRDY, 1'b0, 5'd0);
    repeat (3) tick();
    check("nr_parked", {tx_tp, fsm_state}, {1'b0, 4'd8});
    send_tp(SUB_ERDY, 1'b0, 5'd0);
    expect_tp(1'b1, 5'd1, in_m, 4'd1, "nr_req2");
    send_dph(in_m, 16'd128);
    send_dpp(1'b1);
    in_m = in_m + 5'd1;
    expect_tp(1'b0, 5'd0, in_m, 4'd1, "nr_ack");
    wait_done("nr");

    // DPH and NRDY in the same cycle: the DPH wins.
    issue(1'b1, 4'd9, 16'd0, 16'd256);
    expect_tp(1'b1, 5'd1, in_m, 4'd9, "pri_req");
    rx_dph = 1'b1; rx_dph_seq = in_m; rx_dph_len = 16'd256;
    rx_tp = 1'b1; rx_tp_subtype = SUB_NRDY;
    tick();
    rx_dph = 1'b0; rx_tp = 1'b0;
    check("pri_state", fsm_state, 4'd3);
    send_dpp(1'b1);
    in_m = in_m + 5'd1;
    expect_tp(1'b0, 5'd0, in_m, 4'd9, "pri_ack");
    wait_done("pri");

    // IN STALL.
    issue(1'b1, 4'd2, 16'd0, 16'd0);
    expect_tp(1'b1, 5'd1, in_m, 4'd2, "st_req");
    send_tp(SUB_STALL, 1'b0, 5'd0);
    wait_done("st");
    check("st_errs", {err_timeout, err_retry, err_stall}, 3'b001);
    do_reset();

    // OUT retries exhausted: MAX_RETRY resends, then the next retry aborts.
    issue(1'b0, 4'd3, 16'd32, 16'd0);
    for (int a = 0; a <= MAX_RETRY; a++) begin
      expect_dph(out_m, 16'd32, 4'd3, "rx_dph");
      send_tp(SUB_ACK, 1'b1, out_m + 5'd1);
    end
    wait_done("rx");
    check("rx_errs", {err_timeout, err_retry, err_stall}, 3'b010);
    do_reset();

    // OUT with no response: abort exactly TIMEOUT cycles after tx_dpp_done.
    issue(1'b0, 4'd7, 16'd64, 16'd0);
    expect_dph(out_m, 16'd64, 4'd7, "to_dph");
    repeat (TIMEOUT - 1) tick();
    check("to_early", {err_timeout, xfer_done}, 2'b00);
    tick();
    check("to_flag", err_timeout, 1);
    check("to_done", xfer_done, 1);
    check("to_len", xfer_len, 16'd0);
    tick();
    do_reset();

    // 32 IN transfers from seq 0, then the 33rd request must use seq 0.
    for (int i = 0; i < 33; i++) run_vec('{1'b1, 4'(i), 16'(i * 8), 0, 1'b0, 16'(i * 8)});

    // Reset while in IN_DPP.
    issue(1'b1, 4'd4, 16'd0, 16'd0);
    expect_tp(1'b1, 5'd1, in_m, 4'd4, "mr_req");
    send_dph(in_m, 16'd40);
    check("mr_in_dpp", fsm_state, 4'd3);
    reset_n = 1'b0;
    tick();
    check("mr_state", fsm_state, 4'd0);
    check("mr_cmd_ready", cmd_ready, 0);
    check("mr_reqs", {tx_tp, tx_dph, xfer_done}, 3'b000);
    reset_n = 1'b1;
    exp_q.delete();
    in_m = 5'd0;
    out_m = 5'd0;
    tick();
    check("mr_release_ready", cmd_ready, 1);
    run_vec('{1'b1, 4'd4, 16'd40, 0, 1'b0, 16'd40});

    repeat (3) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
